reg32_dec_unit: RTL and testbench



---
 rtl/reg32_dec_unit.sv | 31 +++
 tb/tb_reg32_dec_unit.sv | 101 ++++++++++
 2 files changed

// File: rtl/reg32_dec_unit.sv
// reg32_dec_unit: 32-bit load-enabled register (async active-high reset) plus 5-to-32 one-hot decoder.
// Define REG_DEC_ENABLE_EN to add decoder enable input E; otherwise the decoder is always enabled.
module reg32_dec_unit #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 5
) (
  input  logic                  C,
  input  logic                  R,
  input  logic [DATA_W-1:0]     D,
  input  logic                  L,
  output logic [DATA_W-1:0]     Q,
  input  logic [SEL_W-1:0]      I,
`ifdef REG_DEC_ENABLE_EN
  input  logic                  E,
`endif
  output logic [(1<<SEL_W)-1:0] De
);
  localparam int OUT_W = 1 << SEL_W;
  logic [DATA_W-1:0] r_q;
  logic [OUT_W-1:0]  w_dec;
  always_ff @(posedge C or posedge R)
    if (R) r_q <= '0;
    else if (L) r_q <= D;
  assign w_dec = OUT_W'(1) << I;
  assign Q = r_q;
`ifdef REG_DEC_ENABLE_EN
  assign De = E ? w_dec : '0;
`else
  assign De = w_dec;
`endif
endmodule

// File: tb/tb_reg32_dec_unit.sv
// tb_reg32_dec_unit: directed self-checking bench for the register and decoder.
module tb_reg32_dec_unit;
  logic        C, R, L;
  logic [31:0] D, Q, De;
  logic [4:0]  I;
`ifdef REG_DEC_ENABLE_EN
  logic        E;
`endif
  int checks = 0;
  int errs = 0;

  reg32_dec_unit dut (
    .C(C), .R(R), .D(D), .L(L), .Q(Q), .I(I),
`ifdef REG_DEC_ENABLE_EN
    .E(E),
`endif
    .De(De)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    #4 C = 1;
    #5 C = 0;
    #1;
  endtask

  initial begin
    C = 0; R = 1; L = 0; D = '0; I = '0;
`ifdef REG_DEC_ENABLE_EN
    E = 1;
`endif
    #2 chk("reset_q", Q, 32'h0);
    R = 0;
    #2;
    I = 5'b10101; #1 chk("dec_spot", De, 32'h0020_0000);
    for (int k = 0; k < 32; k++) begin
      I = 5'(k);
      #1 chk($sformatf("dec_sweep_%0d", k), De, 32'd1 << k);
      chk($sformatf("dec_onehot_%0d", k), 32'($countones(De)), 32'd1);
    end
    D = 32'h02468ace; L = 1;
    pulse();
    chk("load1", Q, 32'h02468ace);
    L = 0; D = 32'h13579bdf;
    #1 chk("hold_pre_edge", Q, 32'h02468ace);
    pulse();
    chk("hold_post_edge", Q, 32'h02468ace);
    L = 1;
    pulse();
    chk("load2", Q, 32'h13579bdf);
    L = 0;
    pulse();
    pulse();
    chk("hold_two_edges", Q, 32'h13579bdf);
    D = 32'h0F0F_0F0F; #1 C = 1; #2 L = 1; #2 C = 0;
    #1 chk("falling_edge_no_effect", Q, 32'h13579bdf);
    L = 0;
    pulse();
    chk("l_change_between_edges", Q, 32'h13579bdf);
    L = 1; D = 32'h02468ace;
    pulse();
    chk("load3", Q, 32'h02468ace);
    L = 0;
    #3 R = 1;
    #1 chk("async_reset", Q, 32'h0);
    L = 1; D = 32'hFFFF_FFFF; I = 5'd9;
    pulse();
    pulse();
    chk("reset_dominates", Q, 32'h0);
    chk("dec_ignores_reset", De, 32'h0000_0200);
    R = 0; D = 32'h13579bdf;
    pulse();
    chk("load4", Q, 32'h13579bdf);
    L = 0;
    #3 R = 1; #2 R = 0;
    #1 chk("mid_reset_pulse", Q, 32'h0);
    pulse();
    chk("stay_zero_unloaded", Q, 32'h0);
    L = 1; D = 32'hA5A5_5A5A;
    pulse();
    chk("load_after_reset", Q, 32'hA5A5_5A5A);
`ifdef REG_DEC_ENABLE_EN
    I = 5'd7; E = 0;
    #1 chk("en_off", De, 32'h0);
    L = 0;
    pulse();
    chk("en_off_reg_hold", Q, 32'hA5A5_5A5A);
    E = 1;
    #1 chk("en_on", De, 32'h0000_0080);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
